// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: round-robin scanner for an external 8:1 mux. It drives
// sel, waits SETTLE_CYCLES, then captures mux_data and offers it downstream.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req[7:0]       per-channel level requests
//   mux_data       data returned by the external mux for the current sel
//   sel[2:0]       registered select driven to the external mux
//   ack[7:0]       one-hot pulse marking the channel just captured
//   out_data/out_ch/out_valid/out_ready  valid/ready output word
module mux_sel_scanner #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       req,
   input  logic [WIDTH-1:0] mux_data,
   output logic [2:0]       sel,
   output logic [7:0]       ack,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       out_ch,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      OFFER  = 2'd2
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       cnt;
   logic [3:0]       cnt_nxt;
   logic [2:0]       last_grant;
   logic [2:0]       last_nxt;
   logic [2:0]       sel_nxt;
   logic [7:0]       ack_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic [2:0]       ch_nxt;
   logic             valid_nxt;

   logic [2:0]       base;
   logic [2:0]       grant;
   logic [2:0]       idx;
   logic             found;
   logic             req_any;
   logic             hs;

   assign req_any = |req;
   assign hs      = out_valid && out_ready;

   // In the handshake cycle last_grant is about to become out_ch, so the
   // search starts from out_ch to see the updated priority this cycle.
   assign base = (state == OFFER) ? out_ch : last_grant;

   always_comb begin
      grant = base;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= 8; i++) begin
         idx = base + 3'(i);
         if (!found && req[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sel_nxt   = sel;
      last_nxt  = last_grant;
      ack_nxt   = '0;
      data_nxt  = out_data;
      ch_nxt    = out_ch;
      valid_nxt = out_valid;
      unique case (state)
         IDLE: begin
            if (req_any) begin
               sel_nxt   = grant;
               cnt_nxt   = '0;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == LAST_CNT) begin
               data_nxt  = mux_data;
               ch_nxt    = sel;
               valid_nxt = 1'b1;
               ack_nxt   = 8'b1 << sel;
               state_nxt = OFFER;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         OFFER: begin
            if (hs) begin
               last_nxt  = out_ch;
               valid_nxt = 1'b0;
               if (req_any) begin
                  sel_nxt   = grant;
                  cnt_nxt   = '0;
                  state_nxt = SETTLE;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         sel        <= '0;
         last_grant <= 3'd7;
         ack        <= '0;
         out_data   <= '0;
         out_ch     <= '0;
         out_valid  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         sel        <= sel_nxt;
         last_grant <= last_nxt;
         ack        <= ack_nxt;
         out_data   <= data_nxt;
         out_ch     <= ch_nxt;
         out_valid  <= valid_nxt;
      end
   end

endmodule

// File: tb/tb_mux_sel_scanner.sv
// tb_mux_sel_scanner: drives two scanners (settle 1 and settle 4) with shared
// stimulus and compares them to a transaction-level reference model.
module tb_mux_sel_scanner;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       out_ready;
   logic [7:0] noise;
   logic [7:0] mux_tab [8];

   logic [7:0] mux_v   [2];
   logic [2:0] sel_v   [2];
   logic [7:0] ack_v   [2];
   logic [7:0] data_v  [2];
   logic [2:0] ch_v    [2];
   logic       valid_v [2];

   int checks   = 0;
   int failures = 0;

   // reference model state, one set per instance
   int         m_sel  [2];
   int         m_last [2];
   bit         m_pend [2];
   int         m_age  [2];
   bit         m_wv   [2];
   logic [7:0] m_wd   [2];
   int         m_wc   [2];
   int         m_ack  [2];

   assign mux_v[0] = mux_tab[sel_v[0]] ^ noise;
   assign mux_v[1] = mux_tab[sel_v[1]] ^ noise;

   mux_sel_scanner #(.WIDTH(8), .SETTLE_CYCLES(1)) u1 (
      .clk(clk), .rst(rst), .req(req), .mux_data(mux_v[0]),
      .sel(sel_v[0]), .ack(ack_v[0]), .out_data(data_v[0]),
      .out_ch(ch_v[0]), .out_valid(valid_v[0]), .out_ready(out_ready)
   );

   mux_sel_scanner #(.WIDTH(8), .SETTLE_CYCLES(4)) u4 (
      .clk(clk), .rst(rst), .req(req), .mux_data(mux_v[1]),
      .sel(sel_v[1]), .ack(ack_v[1]), .out_data(data_v[1]),
      .out_ch(ch_v[1]), .out_valid(valid_v[1]), .out_ready(out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int rr_pick(input logic [7:0] r, input int last);
      for (int i = 1; i <= 8; i++)
         if (r[(last + i) % 8]) return (last + i) % 8;
      return -1;
   endfunction

   // Advance the model by one edge using current inputs, then the clock.
   task automatic step();
      int n;
      int g;
      for (int k = 0; k < 2; k++) begin
         n = (k == 0) ? 1 : 4;
         m_ack[k] = -1;
         if (rst) begin
            m_sel[k] = 0; m_last[k] = 7; m_pend[k] = 0; m_age[k] = 0;
            m_wv[k] = 0; m_wd[k] = 8'h00; m_wc[k] = 0;
         end else if (m_wv[k]) begin
            if (out_ready) begin
               m_last[k] = m_wc[k];
               m_wv[k] = 0;
               g = rr_pick(req, m_last[k]);
               if (g >= 0) begin
                  m_sel[k] = g; m_pend[k] = 1; m_age[k] = 0;
               end
            end
         end else if (m_pend[k]) begin
            m_age[k]++;
            if (m_age[k] == n) begin
               m_wd[k] = mux_tab[m_sel[k]] ^ noise;
               m_wc[k] = m_sel[k];
               m_wv[k] = 1;
               m_pend[k] = 0;
               m_ack[k] = m_sel[k];
            end
         end else begin
            g = rr_pick(req, m_last[k]);
            if (g >= 0) begin
               m_sel[k] = g; m_pend[k] = 1; m_age[k] = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 8'hFF; out_ready = 1'b1; noise = 8'h00;
      for (int i = 0; i < 8; i++) mux_tab[i] = 8'($urandom);
      for (int c = 0; c < 2; c++) begin
         step();
         checks++; if (sel_v[0] !== 3'd0) begin failures++;
            $display("FAIL reset_sel got=%0d exp=0", sel_v[0]); end
         checks++; if (ack_v[0] !== 8'h00) begin failures++;
            $display("FAIL reset_ack got=%h exp=00", ack_v[0]); end
         checks++; if (valid_v[0] !== 1'b0) begin failures++;
            $display("FAIL reset_valid got=%b exp=0", valid_v[0]); end
         checks++; if (data_v[0] !== 8'h00) begin failures++;
            $display("FAIL reset_data got=%h exp=00", data_v[0]); end
         checks++; if (valid_v[1] !== 1'b0) begin failures++;
            $display("FAIL reset_valid4 got=%b exp=0", valid_v[1]); end
      end
      rst = 1'b0;
      step();
      checks++; if (sel_v[0] !== 3'd0) begin failures++;
         $display("FAIL reset_first_sel got=%0d exp=0", sel_v[0]); end
      step();
      checks++; if (valid_v[0] !== 1'b1 || ch_v[0] !== 3'd0) begin failures++;
         $display("FAIL reset_first_grant got=%b/%0d exp=1/0", valid_v[0], ch_v[0]); end
      checks++; if (ack_v[0] !== 8'h01) begin failures++;
         $display("FAIL reset_first_ack got=%h exp=01", ack_v[0]); end
   endtask

   task automatic test_single();
      req = 8'h00; out_ready = 1'b1; noise = 8'h00;
      do_reset();
      mux_tab[3] = 8'hC3;
      req = 8'h08;
      step();
      checks++; if (sel_v[0] !== 3'd3 || valid_v[0] !== 1'b0) begin failures++;
         $display("FAIL single_sel got=%0d/%b exp=3/0", sel_v[0], valid_v[0]); end
      req = 8'h00;
      step();
      checks++; if (valid_v[0] !== 1'b1) begin failures++;
         $display("FAIL single_valid got=%b exp=1", valid_v[0]); end
      checks++; if (data_v[0] !== 8'hC3) begin failures++;
         $display("FAIL single_data got=%h exp=c3", data_v[0]); end
      checks++; if (ch_v[0] !== 3'd3) begin failures++;
         $display("FAIL single_ch got=%0d exp=3", ch_v[0]); end
      checks++; if (ack_v[0] !== 8'h08) begin failures++;
         $display("FAIL single_ack got=%h exp=08", ack_v[0]); end
      step();
      checks++; if (ack_v[0] !== 8'h00 || valid_v[0] !== 1'b0) begin failures++;
         $display("FAIL single_after got=%h/%b exp=00/0", ack_v[0], valid_v[0]); end
   endtask

   task automatic test_round_robin();
      req = 8'h00; out_ready = 1'b1; noise = 8'h00;
      do_reset();
      req = 8'hFF;
      step();
      for (int i = 0; i < 9; i++) begin
         step();
         checks++; if (valid_v[0] !== 1'b1 || ch_v[0] !== 3'(i % 8)) begin failures++;
            $display("FAIL rr_word%0d got=%b/%0d exp=1/%0d", i, valid_v[0], ch_v[0], i % 8); end
         checks++; if (ack_v[0] !== 8'(1 << (i % 8))) begin failures++;
            $display("FAIL rr_ack%0d got=%h exp=%h", i, ack_v[0], 8'(1 << (i % 8))); end
         step();
         checks++; if (valid_v[0] !== 1'b0) begin failures++;
            $display("FAIL rr_gap%0d got=%b exp=0", i, valid_v[0]); end
      end
   endtask

   task automatic test_backpressure();
      req = 8'h00; out_ready = 1'b0; noise = 8'h00;
      do_reset();
      mux_tab[2] = 8'h5A;
      req = 8'h04;
      step();
      step();
      req = 8'h00;
      checks++; if (valid_v[0] !== 1'b1 || data_v[0] !== 8'h5A) begin failures++;
         $display("FAIL bp_capture got=%b/%h exp=1/5a", valid_v[0], data_v[0]); end
      for (int c = 0; c < 5; c++) begin
         noise = 8'($urandom) | 8'h01;
         step();
         checks++;
         if (valid_v[0] !== 1'b1 || data_v[0] !== 8'h5A ||
             ch_v[0] !== 3'd2 || sel_v[0] !== 3'd2 || ack_v[0] !== 8'h00) begin
            failures++;
            $display("FAIL bp_hold%0d got=%b/%h/%0d/%0d/%h exp=1/5a/2/2/00",
                     c, valid_v[0], data_v[0], ch_v[0], sel_v[0], ack_v[0]);
         end
      end
      out_ready = 1'b1;
      step();
      checks++; if (valid_v[0] !== 1'b0) begin failures++;
         $display("FAIL bp_transfer got=%b exp=0", valid_v[0]); end
      step();
      checks++; if (valid_v[0] !== 1'b0 || ack_v[0] !== 8'h00) begin failures++;
         $display("FAIL bp_single got=%b/%h exp=0/00", valid_v[0], ack_v[0]); end
      noise = 8'h00;
   endtask

   task automatic test_reset_offer();
      req = 8'h00; out_ready = 1'b0; noise = 8'h00;
      do_reset();
      req = 8'h20;
      step();
      step();
      checks++; if (valid_v[0] !== 1'b1 || ch_v[0] !== 3'd5) begin failures++;
         $display("FAIL ro_offer got=%b/%0d exp=1/5", valid_v[0], ch_v[0]); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (valid_v[0] !== 1'b0 || ack_v[0] !== 8'h00 || sel_v[0] !== 3'd0) begin
         failures++;
         $display("FAIL ro_discard got=%b/%h/%0d exp=0/00/0", valid_v[0], ack_v[0], sel_v[0]); end
      step();
      checks++; if (sel_v[0] !== 3'd5 || valid_v[0] !== 1'b0) begin failures++;
         $display("FAIL ro_regrant got=%0d/%b exp=5/0", sel_v[0], valid_v[0]); end
      step();
      checks++; if (valid_v[0] !== 1'b1 || ack_v[0] !== 8'h20) begin failures++;
         $display("FAIL ro_recapture got=%b/%h exp=1/20", valid_v[0], ack_v[0]); end
   endtask

   task automatic test_settle4();
      req = 8'h00; out_ready = 1'b1; noise = 8'h00;
      do_reset();
      mux_tab[0] = 8'h11;
      req = 8'h01;
      step();
      req = 8'h00;
      checks++; if (sel_v[1] !== 3'd0 || valid_v[1] !== 1'b0) begin failures++;
         $display("FAIL s4_enter got=%0d/%b exp=0/0", sel_v[1], valid_v[1]); end
      for (int e = 2; e <= 4; e++) begin
         mux_tab[0] = 8'(8'h20 + e);
         step();
         checks++; if (valid_v[1] !== 1'b0 || ack_v[1] !== 8'h00) begin failures++;
            $display("FAIL s4_wait%0d got=%b/%h exp=0/00", e, valid_v[1], ack_v[1]); end
      end
      mux_tab[0] = 8'h99;
      step();
      checks++; if (valid_v[1] !== 1'b1 || data_v[1] !== 8'h99) begin failures++;
         $display("FAIL s4_capture got=%b/%h exp=1/99", valid_v[1], data_v[1]); end
      checks++; if (ch_v[1] !== 3'd0 || ack_v[1] !== 8'h01) begin failures++;
         $display("FAIL s4_ack got=%0d/%h exp=0/01", ch_v[1], ack_v[1]); end
   endtask

   task automatic test_random();
      logic [7:0] exp_ack;
      req = 8'h00; out_ready = 1'b1; noise = 8'h00;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 59) == 0);
         mux_tab[$urandom_range(0, 7)] = 8'($urandom);
         if ($urandom_range(0, 3) == 0) noise = 8'($urandom);
         step();
         for (int k = 0; k < 2; k++) begin
            exp_ack = (m_ack[k] < 0) ? 8'h00 : 8'(1 << m_ack[k]);
            checks++; if (sel_v[k] !== 3'(m_sel[k])) begin failures++;
               $display("FAIL rnd_sel i%0d c%0d got=%0d exp=%0d", k, c, sel_v[k], m_sel[k]); end
            checks++; if (ack_v[k] !== exp_ack) begin failures++;
               $display("FAIL rnd_ack i%0d c%0d got=%h exp=%h", k, c, ack_v[k], exp_ack); end
            checks++; if (valid_v[k] !== m_wv[k]) begin failures++;
               $display("FAIL rnd_valid i%0d c%0d got=%b exp=%b", k, c, valid_v[k], m_wv[k]); end
            checks++; if (ch_v[k] !== 3'(m_wc[k])) begin failures++;
               $display("FAIL rnd_ch i%0d c%0d got=%0d exp=%0d", k, c, ch_v[k], m_wc[k]); end
            checks++; if (data_v[k] !== m_wd[k]) begin failures++;
               $display("FAIL rnd_data i%0d c%0d got=%h exp=%h", k, c, data_v[k], m_wd[k]); end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 8'h00; out_ready = 1'b0; noise = 8'h00;
      for (int i = 0; i < 8; i++) mux_tab[i] = 8'h00;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_offer();
      test_settle4();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
